// File: rtl/usb_rx_if.sv
// Buffer/protocol-side signal bundle of the USB full-speed receive path.
// The receiver drives everything except the buffer occupancy it reads back.
interface usb_rx_if;
    logic [6:0] buffer_occupancy;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data;
    logic       flush;
    logic [2:0] rx_packet;
    logic       rx_data_ready;
    logic       rx_transfer_active;
    logic       rx_error;

    modport master (
        input  buffer_occupancy,
        output rx_packet_data, store_rx_packet_data, flush,
        output rx_packet, rx_data_ready, rx_transfer_active, rx_error
    );

    modport slave (
        output buffer_occupancy,
        input  rx_packet_data, store_rx_packet_data, flush,
        input  rx_packet, rx_data_ready, rx_transfer_active, rx_error
    );
endinterface

// File: rtl/usb_rx.sv
// USB full-speed receiver: line sync, bit recovery, NRZI decode, unstuffing,
// SYNC/PID checks and EOP detection; DATA payload bytes are pushed to the buffer.
module usb_rx #(
    parameter int unsigned CLKS_PER_BIT  = 8,
    parameter int unsigned SAMPLE_OFFSET = 3
) (
    input  logic     clk,
    input  logic     n_rst,
    input  logic     dp_in,
    input  logic     dm_in,
    usb_rx_if.master bus
);
    localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [6:0]  BUF_FULL = 7'd64;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOP, S_DONE, S_ERR
    } state_t;

    state_t             state, state_nxt;
    logic               dp_meta, dp_sync, dp_prev, dm_meta, dm_sync;
    logic [CNT_W-1:0]   cnt;
    logic               sample_c, fall_c, se0_c, j_c, nrzi_c, pid_ok_c;
    logic [7:0]         byte_c;
    logic [2:0]         pid_c;
    logic               prev_dp, prev_dp_nxt;
    logic [6:0]         sreg, sreg_nxt;
    logic [3:0]         bit_cnt, bit_cnt_nxt;
    logic [2:0]         ones, ones_nxt;
    logic [1:0]         se0_cnt, se0_cnt_nxt;
    logic [2:0]         j_cnt, j_cnt_nxt;
    logic [2:0]         pid_code, pid_code_nxt;
    logic [7:0]         data_q, data_nxt;
    logic               store_q, store_nxt, flush_q, flush_nxt, ready_q, ready_nxt;
    logic               active_q, active_nxt, error_q, error_nxt;
    logic [2:0]         packet_q, packet_nxt;

    // Two-flop synchronisers and a bit-phase counter re-aligned on every D+ edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta <= 1'b1;
            dp_sync <= 1'b1;
            dp_prev <= 1'b1;
            dm_meta <= 1'b0;
            dm_sync <= 1'b0;
            cnt     <= '0;
        end else begin
            dp_meta <= dp_in;
            dp_sync <= dp_meta;
            dp_prev <= dp_sync;
            dm_meta <= dm_in;
            dm_sync <= dm_meta;
            if (dp_sync != dp_prev || cnt == CNT_W'(CLKS_PER_BIT - 1))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign sample_c = (cnt == CNT_W'(SAMPLE_OFFSET));
    assign fall_c   = dp_prev & ~dp_sync;
    assign se0_c    = ~dp_sync & ~dm_sync;
    assign j_c      = dp_sync & ~dm_sync;
    assign nrzi_c   = (dp_sync == prev_dp);
    assign byte_c   = {nrzi_c, sreg};

    // PID byte to packet code; 0 marks an unsupported or malformed PID
    always_comb begin
        case (byte_c)
            8'hE1:   pid_c = 3'd1;
            8'h69:   pid_c = 3'd2;
            8'hC3:   pid_c = 3'd3;
            8'h4B:   pid_c = 3'd4;
            8'hD2:   pid_c = 3'd5;
            8'h5A:   pid_c = 3'd6;
            8'h1E:   pid_c = 3'd7;
            default: pid_c = 3'd0;
        endcase
        pid_ok_c = (byte_c[7:4] == ~byte_c[3:0]) && (pid_c != 3'd0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        prev_dp_nxt  = prev_dp;
        sreg_nxt     = sreg;
        bit_cnt_nxt  = bit_cnt;
        ones_nxt     = ones;
        se0_cnt_nxt  = se0_cnt;
        j_cnt_nxt    = j_cnt;
        pid_code_nxt = pid_code;
        data_nxt     = data_q;
        store_nxt    = 1'b0;
        flush_nxt    = 1'b0;
        ready_nxt    = 1'b0;
        packet_nxt   = packet_q;
        active_nxt   = active_q;
        error_nxt    = error_q;

        case (state)
            S_IDLE: begin
                prev_dp_nxt = 1'b1;
                ones_nxt    = 3'd0;
                bit_cnt_nxt = 4'd0;
                if (fall_c) begin
                    state_nxt  = S_SYNC;
                    active_nxt = 1'b1;
                    error_nxt  = 1'b0;
                    packet_nxt = 3'd0;
                end
            end
            S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOP: begin
                if (sample_c) begin
                    prev_dp_nxt = dp_sync;
                    // SE0 outranks the stuff slot so an EOP right after six ones is honoured
                    if (se0_c) begin
                        ones_nxt = 3'd0;
                        if (state == S_EOP) begin
                            if (se0_cnt != 2'd2) se0_cnt_nxt = se0_cnt + 2'd1;
                        end else if (state == S_DATA && bit_cnt == 4'd0) begin
                            state_nxt   = S_EOP;
                            se0_cnt_nxt = 2'd1;
                        end else begin
                            state_nxt = S_ERR;
                        end
                    end else if (ones == 3'd6) begin
                        ones_nxt = 3'd0;
                        if (nrzi_c) state_nxt = S_ERR;
                    end else if (state == S_EOP) begin
                        state_nxt = (j_c && se0_cnt == 2'd2) ? S_DONE : S_ERR;
                    end else begin
                        ones_nxt    = nrzi_c ? ones + 3'd1 : 3'd0;
                        sreg_nxt    = byte_c[7:1];
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (state == S_TOKEN) begin
                            if (bit_cnt == 4'd15) begin
                                state_nxt   = S_EOP;
                                se0_cnt_nxt = 2'd0;
                            end
                        end else if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = 4'd0;
                            case (state)
                                S_SYNC: state_nxt = (byte_c == 8'h80) ? S_PID : S_ERR;
                                S_PID: begin
                                    pid_code_nxt = pid_c;
                                    se0_cnt_nxt  = 2'd0;
                                    if (!pid_ok_c) begin
                                        state_nxt = S_ERR;
                                    end else if (pid_c == 3'd3 || pid_c == 3'd4) begin
                                        state_nxt = S_DATA;
                                        flush_nxt = 1'b1;
                                    end else if (pid_c == 3'd1 || pid_c == 3'd2) begin
                                        state_nxt = S_TOKEN;
                                    end else begin
                                        state_nxt = S_EOP;
                                    end
                                end
                                default: begin
                                    if (bus.buffer_occupancy == BUF_FULL) begin
                                        state_nxt = S_ERR;
                                    end else begin
                                        data_nxt  = byte_c;
                                        store_nxt = 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
            end
            S_DONE: begin
                packet_nxt = pid_code;
                ready_nxt  = 1'b1;
                active_nxt = 1'b0;
                state_nxt  = S_IDLE;
            end
            S_ERR: begin
                if (sample_c) begin
                    if (!j_c) begin
                        j_cnt_nxt = 3'd0;
                    end else if (j_cnt == 3'd7) begin
                        state_nxt  = S_IDLE;
                        active_nxt = 1'b0;
                    end else begin
                        j_cnt_nxt = j_cnt + 3'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt == S_ERR && state != S_ERR) begin
            error_nxt  = 1'b1;
            packet_nxt = 3'd0;
            j_cnt_nxt  = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_dp  <= 1'b1;
            sreg     <= '0;
            bit_cnt  <= '0;
            ones     <= '0;
            se0_cnt  <= '0;
            j_cnt    <= '0;
            pid_code <= '0;
            data_q   <= '0;
            store_q  <= 1'b0;
            flush_q  <= 1'b0;
            ready_q  <= 1'b0;
            packet_q <= '0;
            active_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            prev_dp  <= prev_dp_nxt;
            sreg     <= sreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            ones     <= ones_nxt;
            se0_cnt  <= se0_cnt_nxt;
            j_cnt    <= j_cnt_nxt;
            pid_code <= pid_code_nxt;
            data_q   <= data_nxt;
            store_q  <= store_nxt;
            flush_q  <= flush_nxt;
            ready_q  <= ready_nxt;
            packet_q <= packet_nxt;
            active_q <= active_nxt;
            error_q  <= error_nxt;
        end
    end

    assign bus.rx_packet_data       = data_q;
    assign bus.store_rx_packet_data = store_q;
    assign bus.flush                = flush_q;
    assign bus.rx_packet            = packet_q;
    assign bus.rx_data_ready        = ready_q;
    assign bus.rx_transfer_active   = active_q;
    assign bus.rx_error             = error_q;
endmodule
